dmem_portb_arb: RTL and testbench

- Two-requester arbiter and sequencer for data-memory port B (clkb/addrb/dinb/web/doutb), which is otherwise tied off.
- Requester 0 is the host register interface. Requester 1 is the packet DMA engine.
- Arbitration is round-robin. Commands are latched, driven to the BRAM for one cycle, and the 1-cycle BRAM read latency is absorbed before returning read data with a valid pulse.
- The CPU keeps exclusive use of port A; this block never touches port A.

---
 rtl/dmem_portb_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_portb_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_portb_arb.sv
// Round-robin arbiter/sequencer that shares data-memory port B between the host
// register interface (requester 0) and the packet DMA (requester 1).
// Optional grant/conflict counters are enabled by defining DMEM_ARB_STATS_EN.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dmem_portb_arb #(
  parameter int ADDR_W = `DMEM_ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic [DATA_W-1:0] dinb_o,
  output logic              web_o,
  input  logic [DATA_W-1:0] doutb_i
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [15:0]       gnt_cnt0_o,
  output logic [15:0]       gnt_cnt1_o,
  output logic [15:0]       conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                winner_r;
  logic                rr_last_r;

  logic                sel_valid_s;
  logic                sel_id_s;

  logic                winner_nx_s;
  logic                rr_last_nx_s;
  logic [ADDR_W-1:0]   addrb_nx_s;
  logic [DATA_W-1:0]   dinb_nx_s;
  logic                web_nx_s;
  logic                gnt0_nx_s;
  logic                gnt1_nx_s;
  logic                rvalid0_nx_s;
  logic                rvalid1_nx_s;
  logic [DATA_W-1:0]   rdata_nx_s;
  logic                busy_nx_s;

  // Requester selection: on contention the requester that did not win last time goes.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_id_s    = 1'b0;
    if (req0_i && req1_i) begin
      sel_valid_s = 1'b1;
      sel_id_s    = ~rr_last_r;
    end else if (req0_i) begin
      sel_valid_s = 1'b1;
      sel_id_s    = 1'b0;
    end else if (req1_i) begin
      sel_valid_s = 1'b1;
      sel_id_s    = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
      sel_id_s    = 1'b0;
    end
  end

  // Next-state logic; web_o still holds the latched write flag while in ISSUE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (web_o) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DATA;
        end
      end
      DATA:    state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output logic: computes the values every registered output takes at the next edge.
  always_comb begin
    winner_nx_s  = winner_r;
    rr_last_nx_s = rr_last_r;
    addrb_nx_s   = addrb_o;
    dinb_nx_s    = dinb_o;
    web_nx_s     = 1'b0;
    gnt0_nx_s    = 1'b0;
    gnt1_nx_s    = 1'b0;
    rvalid0_nx_s = 1'b0;
    rvalid1_nx_s = 1'b0;
    rdata_nx_s   = rdata_o;
    busy_nx_s    = (state_nx_s != IDLE);
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          winner_nx_s  = sel_id_s;
          rr_last_nx_s = sel_id_s;
          addrb_nx_s   = sel_id_s ? addr1_i  : addr0_i;
          dinb_nx_s    = sel_id_s ? wdata1_i : wdata0_i;
          web_nx_s     = sel_id_s ? we1_i    : we0_i;
          gnt0_nx_s    = ~sel_id_s;
          gnt1_nx_s    = sel_id_s;
        end else begin
          web_nx_s     = 1'b0;
        end
      end
      ISSUE: begin
        web_nx_s = 1'b0;
      end
      DATA: begin
        // BRAM read data appears one cycle after the address was presented
        rdata_nx_s   = doutb_i;
        rvalid0_nx_s = ~winner_r;
        rvalid1_nx_s = winner_r;
      end
      RESP: begin
        web_nx_s = 1'b0;
      end
      default: begin
        web_nx_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      winner_r  <= 1'b0;
      rr_last_r <= 1'b1;
      addrb_o   <= {ADDR_W{1'b0}};
      dinb_o    <= {DATA_W{1'b0}};
      web_o     <= 1'b0;
      gnt0_o    <= 1'b0;
      gnt1_o    <= 1'b0;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata_o   <= {DATA_W{1'b0}};
      busy_o    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      winner_r  <= winner_nx_s;
      rr_last_r <= rr_last_nx_s;
      addrb_o   <= addrb_nx_s;
      dinb_o    <= dinb_nx_s;
      web_o     <= web_nx_s;
      gnt0_o    <= gnt0_nx_s;
      gnt1_o    <= gnt1_nx_s;
      rvalid0_o <= rvalid0_nx_s;
      rvalid1_o <= rvalid1_nx_s;
      rdata_o   <= rdata_nx_s;
      busy_o    <= busy_nx_s;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic grant_s;
  logic conflict_s;

  // Grant and contention events, both taken from IDLE-cycle decisions.
  always_comb begin
    grant_s    = (state_r == IDLE) && sel_valid_s;
    conflict_s = (state_r == IDLE) && req0_i && req1_i;
  end

  // Saturating statistics counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_o     <= 16'd0;
      gnt_cnt1_o     <= 16'd0;
      conflict_cnt_o <= 16'd0;
    end else if (stats_clr_i) begin
      gnt_cnt0_o     <= 16'd0;
      gnt_cnt1_o     <= 16'd0;
      conflict_cnt_o <= 16'd0;
    end else begin
      if (grant_s && !sel_id_s) begin
        gnt_cnt0_o <= sat_inc16(gnt_cnt0_o);
      end
      if (grant_s && sel_id_s) begin
        gnt_cnt1_o <= sat_inc16(gnt_cnt1_o);
      end
      if (conflict_s) begin
        conflict_cnt_o <= sat_inc16(conflict_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_portb_arb.sv
// Directed self-checking bench for dmem_portb_arb with a behavioural BRAM on port B.
module tb_dmem_portb_arb;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, web;
  logic [DW-1:0] rdata, dinb, doutb;
  logic [AW-1:0] addrb;
`ifdef DMEM_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   gcnt0, gcnt1, ccnt;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_portb_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .busy_o(busy),
    .addrb_o(addrb), .dinb_o(dinb), .web_o(web), .doutb_i(doutb)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr_i(stats_clr), .gnt_cnt0_o(gcnt0), .gnt_cnt1_o(gcnt1), .conflict_cnt_o(ccnt)
`endif
  );

  // Single-port read-first BRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (web) mem[addrb] <= dinb;
    doutb <= mem[addrb];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ng;
    int nr;

    // reset state
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {27'd0, gnt0, gnt1, rvalid0, rvalid1, web}, 32'd0);
    chk("rst_addrb", {22'd0, addrb}, 32'd0);
    chk("rst_dinb", dinb, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    step();

    // requester 0 write 0x05 <- DEADBEEF
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 32'hDEADBEEF;
    step();
    chk("w0_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    chk("w0_web", {31'd0, web}, 32'd1);
    chk("w0_addrb", {22'd0, addrb}, 32'h5);
    chk("w0_dinb", dinb, 32'hDEADBEEF);
    chk("w0_busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0; we0 = 1'b0;
    step();
    chk("w0_web_off", {31'd0, web}, 32'd0);
    chk("w0_idle", {31'd0, busy}, 32'd0);
    chk("w0_porta", mem[5], 32'hDEADBEEF);

    // requester 1 read 0x05
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005;
    step();
    chk("r1_gnt", {30'd0, gnt0, gnt1}, 32'd1);
    chk("r1_web", {31'd0, web}, 32'd0);
    req1 = 1'b0;
    step();
    chk("r1_c2_rv", {30'd0, rvalid0, rvalid1}, 32'd0);
    step();
    chk("r1_c3_rv", {30'd0, rvalid0, rvalid1}, 32'd1);
    chk("r1_rdata", rdata, 32'hDEADBEEF);
    step();
    chk("r1_c4_rv", {30'd0, rvalid0, rvalid1}, 32'd0);
    chk("r1_c4_rdata_hold", rdata, 32'hDEADBEEF);

    // lone requester 1 write while it also won last time
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h009; wdata1 = 32'h12345678;
    step();
    chk("w1_gnt", {30'd0, gnt0, gnt1}, 32'd1);
    req1 = 1'b0; we1 = 1'b0;
    step();
    chk("w1_porta", mem[9], 32'h12345678);

    // both reading continuously: strict alternation starting with 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h009;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && (ng < 6 || nr < 6); c++) begin
      step();
      chk("fair_two_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("fair_two_rv", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (gnt0 || gnt1) begin
        chk($sformatf("fair_order%0d", ng), {31'd0, gnt1}, ng % 2);
        ng++;
        if (ng == 6) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
      if (rvalid0 || rvalid1) begin
        chk($sformatf("fair_rv_who%0d", nr), {31'd0, rvalid1}, nr % 2);
        chk($sformatf("fair_rdata%0d", nr), rdata, (nr % 2 == 1) ? 32'h12345678 : 32'hDEADBEEF);
        nr++;
      end
    end
    chk("fair_grants", ng, 32'd6);
    chk("fair_rvalids", nr, 32'd6);
    step();

    // reset during DATA of a requester 0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h009;
    step();
    chk("rr_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    step();
    chk("rr_busy_data", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_busy_clr", {31'd0, busy}, 32'd0);
    chk("rr_flags_clr", {27'd0, gnt0, gnt1, rvalid0, rvalid1, web}, 32'd0);
    chk("rr_rdata_clr", rdata, 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rr_no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h009;
    step();
    chk("rr_first_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    chk("rr_rv0", {30'd0, rvalid0, rvalid1}, 32'd2);
    chk("rr_rdata", rdata, 32'hDEADBEEF);
    step();

    // three back-to-back writes from requester 0
    req0 = 1'b1; we0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr0 = 10'h020 + AW'(k);
      wdata0 = 32'hA5A50000 + k;
      step();
      chk($sformatf("bw_gnt%0d", k), {30'd0, gnt0, gnt1}, 32'd2);
      chk($sformatf("bw_web%0d", k), {31'd0, web}, 32'd1);
      chk($sformatf("bw_addrb%0d", k), {22'd0, addrb}, 32'h20 + k);
      if (k == 2) begin
        req0 = 1'b0; we0 = 1'b0;
      end
      step();
      chk($sformatf("bw_gap_gnt%0d", k), {30'd0, gnt0, gnt1}, 32'd0);
      chk($sformatf("bw_gap_web%0d", k), {31'd0, web}, 32'd0);
    end
    chk("bw_mem0", mem[32], 32'hA5A50000);
    chk("bw_mem1", mem[33], 32'hA5A50001);
    chk("bw_mem2", mem[34], 32'hA5A50002);

`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("st_clr0", {gcnt0, gcnt1}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h009;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      if (gnt0 || gnt1) begin
        ng++;
        if (ng == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    chk("st_grants", ng, 32'd4);
    step(); step(); step();
    chk("st_gcnt0", {16'd0, gcnt0}, 32'd2);
    chk("st_gcnt1", {16'd0, gcnt1}, 32'd2);
    chk("st_ccnt", {16'd0, ccnt}, 32'd4);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("st_clr_g", {gcnt0, gcnt1}, 32'd0);
    chk("st_clr_c", {16'd0, ccnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
